hs4_rx_sink: RTL

Clocked consumer end of the four-phase req/ack micropipeline formed by the asynchronous FIFO stages. Synchronizes the incoming request, captures bundled data, returns the acknowledge, and presents the words to synchronous logic through a small valid/ready buffer. It terminates the last asynchronous stage of the FIFO chain in the clocked domain.

---
 rtl/hs4_rx_pkg.sv | 25 ++
 rtl/hs4_rx_sink_if.sv | 31 +++
 rtl/hs4_rx_sink_sync.sv | 24 ++
 rtl/hs4_rx_sink.sv | 97 +++++++++
 4 files changed

// File: rtl/hs4_rx_pkg.sv
// hs4_rx_pkg: shared types and constants for the hs4_rx_sink block.
//   state_e      - handshake FSM states (IDLE, ACK_HI)
//   SYNC_STAGES  - request synchronizer depth: 3 when HS4_RX_SYNC3_EN is
//                  defined, otherwise 2
//   lvl_w()      - width of the buffered-word counter for a given depth
package hs4_rx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } state_e;

`ifdef HS4_RX_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // The counter must reach DEPTH itself, so it needs one bit more than the
  // pointers.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs4_rx_sink_if.sv
// hs4_rx_sink_if: four-phase input side and valid/ready output side of the
// hs4_rx_sink block.
//   req_in/data_in/ack_out          - bundled-data four-phase handshake
//   out_valid/out_ready/out_data    - synchronous stream of buffered words
//   level                           - buffered word count
// Modports: slave = the sink block, master = the environment driving it.
interface hs4_rx_sink_if #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4
);
  import hs4_rx_pkg::*;

  logic                        req_in;
  logic [DATA_WIDTH-1:0]       data_in;
  logic                        ack_out;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [lvl_w(DEPTH)-1:0]     level;

  modport master (
    output req_in, data_in, out_ready,
    input  ack_out, out_valid, out_data, level
  );

  modport slave (
    input  req_in, data_in, out_ready,
    output ack_out, out_valid, out_data, level
  );

endinterface

// File: rtl/hs4_rx_sink_sync.sv
// hs_sync: N-flop single-bit synchronizer, synchronous active-high reset to 0.
//   clk, rst - clock and reset
//   d_i      - asynchronous input
//   q_o      - synchronized output (last flop)
// N must be at least 2.
module hs_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= '0;
    else     ff_q <= {ff_q[N-2:0], d_i};
  end

  assign q_o = ff_q[N-1];

endmodule

// File: rtl/hs4_rx_sink.sv
// hs4_rx_sink: clocked terminator of a four-phase req/ack async FIFO chain.
// The request is synchronized (data is bundled and never synchronized), one
// word is pushed per full req/ack cycle into a DEPTH-entry circular buffer,
// and the buffer is drained through a valid/ready port.
//   clk, rst  - system clock, synchronous active-high reset
//   bus       - hs4_rx_sink_if.slave (handshake in, stream out, level)
// Build option: HS4_RX_SYNC3_EN selects a 3-flop request synchronizer.
module hs4_rx_sink
  import hs4_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst,
  hs4_rx_sink_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic                  req_s;
  state_e                state_q;
  logic                  ack_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  full, push, pop;

  hs_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.req_in),
    .q_o (req_s)
  );

  // Full uses the registered level: a pop this cycle frees a slot only for
  // the next cycle, keeping the push decision independent of out_ready.
  assign full = (level_q == LW'(DEPTH));
  assign push = (state_q == IDLE) && req_s && !full;
  assign pop  = (level_q != '0) && bus.out_ready;

  // A full buffer simply holds IDLE with ack low, which stalls the sender.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (push) begin
          ack_q   <= 1'b1;
          state_q <= ACK_HI;
        end
        ACK_HI: if (!req_s) begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // Storage is not reset; reset empties the buffer through the counters.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.ack_out   = ack_q;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.level     = level_q;

endmodule
